// File: rtl/qea_job_sequencer.sv
// Job sequencer: loads gate context, initialises the state RAM to |0>, starts the QEA and streams the result rows.
// Optional build macro QEA_SEQ_CYCLE_COUNT_EN adds o_run_cycles (start-to-complete cycles of the last finished job).
module qea_job_sequencer #(
    parameter int PE_NUM_WIDTH            = 2,
    parameter int PE_NUM                  = 4,
    parameter int DATA_WIDTH              = 32,
    parameter int MAX_QBIT_WIDTH          = 6,
    parameter int STATE_ADDR_WIDTH        = 16,
    parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
    parameter int NUM_FRAC_BIT            = 30,
    parameter int TIMEOUT_CYCLES          = 1048576
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 i_job_valid,
    output logic                                 o_job_ready,
    input  logic [MAX_QBIT_WIDTH-1:0]            i_job_qbit_num,
    input  logic [GATE_CONTEXT_ADDR_WIDTH:0]     i_job_ctx_num,
    input  logic                                 i_ctx_valid,
    output logic                                 o_ctx_ready,
    input  logic [2*DATA_WIDTH-1:0]              i_ctx_data,
    output logic                                 o_qea_start,
    output logic [MAX_QBIT_WIDTH-1:0]            o_qea_qbit_num,
    output logic                                 o_ctx_en,
    output logic                                 o_ctx_wea,
    output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_ctx_addr,
    output logic [2*DATA_WIDTH-1:0]              o_ctx_data,
    output logic                                 o_state_ena,
    output logic                                 o_state_wea,
    output logic [STATE_ADDR_WIDTH-1:0]          o_state_addra,
    output logic [PE_NUM*2*DATA_WIDTH-1:0]       o_state_dina,
    input  logic                                 i_qea_complete,
    input  logic [PE_NUM*2*DATA_WIDTH-1:0]       i_state_dout,
    output logic                                 o_rd_valid,
    input  logic                                 i_rd_ready,
    output logic [PE_NUM*2*DATA_WIDTH-1:0]       o_rd_data,
    output logic                                 o_rd_last,
    output logic                                 o_busy,
    output logic                                 o_error
`ifdef QEA_SEQ_CYCLE_COUNT_EN
    ,
    output logic [31:0]                          o_run_cycles
`endif
);

    localparam int ROW_W  = PE_NUM*2*DATA_WIDTH;
    localparam int CNT_W  = STATE_ADDR_WIDTH+1;
    localparam int CTXN_W = GATE_CONTEXT_ADDR_WIDTH+1;
    localparam logic [DATA_WIDTH-1:0] ONE_Q = DATA_WIDTH'(1) << NUM_FRAC_BIT;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD_CTX = 3'd1;
    localparam logic [2:0] S_INIT_ST  = 3'd2;
    localparam logic [2:0] S_START    = 3'd3;
    localparam logic [2:0] S_RUN      = 3'd4;
    localparam logic [2:0] S_RD_REQ   = 3'd5;
    localparam logic [2:0] S_RD_WAIT  = 3'd6;
    localparam logic [2:0] S_RD_OUT   = 3'd7;

    logic [2:0]                         r_state;
    logic [MAX_QBIT_WIDTH-1:0]          r_qbit_num;
    logic [CTXN_W-1:0]                  r_ctx_num;
    logic [CTXN_W-1:0]                  r_ctx_cnt;
    logic [CNT_W-1:0]                   r_row;
    logic [31:0]                        r_cyc;
    logic                               r_error;
    logic                               r_ctx_en;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0] r_ctx_addr;
    logic [2*DATA_WIDTH-1:0]            r_ctx_data;
    logic                               r_rd_valid;
    logic [ROW_W-1:0]                   r_rd_data;
    logic                               r_rd_last;

    logic [MAX_QBIT_WIDTH-1:0]          w_shift;
    logic [CNT_W-1:0]                   w_rows_m1;
    logic                               w_job_bad;
    logic [ROW_W-1:0]                   w_row0_word;

    // Row counter is one bit wider than the address so a full 2^STATE_ADDR_WIDTH sweep never wraps.
    assign w_shift   = r_qbit_num - MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
    assign w_rows_m1 = (CNT_W'(1) << w_shift) - CNT_W'(1);
    assign w_job_bad = (i_job_qbit_num < MAX_QBIT_WIDTH'(PE_NUM_WIDTH))
                    || (32'(i_job_qbit_num) > 32'(PE_NUM_WIDTH + STATE_ADDR_WIDTH))
                    || (i_job_ctx_num == '0);

    // Amplitude 1.0+0j sits in the real half of the top lane of row 0.
    genvar gi;
    generate
        for (gi = 0; gi < PE_NUM; gi++) begin : g_row0
            assign w_row0_word[gi*2*DATA_WIDTH +: 2*DATA_WIDTH] =
                (gi == PE_NUM-1) ? {ONE_Q, {DATA_WIDTH{1'b0}}} : {2*DATA_WIDTH{1'b0}};
        end
    endgenerate

    assign o_job_ready    = (r_state == S_IDLE);
    assign o_busy         = (r_state != S_IDLE);
    assign o_ctx_ready    = (r_state == S_LOAD_CTX);
    assign o_qea_start    = (r_state == S_START);
    assign o_qea_qbit_num = r_qbit_num;
    assign o_ctx_en       = r_ctx_en;
    assign o_ctx_wea      = r_ctx_en;
    assign o_ctx_addr     = r_ctx_addr;
    assign o_ctx_data     = r_ctx_data;
    assign o_state_ena    = (r_state == S_INIT_ST) || (r_state == S_RD_REQ);
    assign o_state_wea    = (r_state == S_INIT_ST);
    assign o_state_addra  = r_row[STATE_ADDR_WIDTH-1:0];
    assign o_state_dina   = ((r_state == S_INIT_ST) && (r_row == '0)) ? w_row0_word : '0;
    assign o_rd_valid     = r_rd_valid;
    assign o_rd_data      = r_rd_data;
    assign o_rd_last      = r_rd_last;
    assign o_error        = r_error;

`ifdef QEA_SEQ_CYCLE_COUNT_EN
    logic [31:0] r_run_cycles;
    assign o_run_cycles = r_run_cycles;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_qbit_num <= '0;
            r_ctx_num  <= '0;
            r_ctx_cnt  <= '0;
            r_row      <= '0;
            r_cyc      <= '0;
            r_error    <= 1'b0;
            r_ctx_en   <= 1'b0;
            r_ctx_addr <= '0;
            r_ctx_data <= '0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_rd_last  <= 1'b0;
`ifdef QEA_SEQ_CYCLE_COUNT_EN
            r_run_cycles <= '0;
`endif
        end else begin
            r_error  <= 1'b0;
            r_ctx_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_job_valid) begin
                        r_qbit_num <= i_job_qbit_num;
                        r_ctx_num  <= i_job_ctx_num;
                        r_ctx_cnt  <= '0;
                        r_row      <= '0;
                        if (w_job_bad) r_error <= 1'b1;
                        else           r_state <= S_LOAD_CTX;
                    end
                end
                S_LOAD_CTX: begin
                    if (i_ctx_valid) begin
                        r_ctx_en   <= 1'b1;
                        r_ctx_addr <= r_ctx_cnt[GATE_CONTEXT_ADDR_WIDTH-1:0];
                        r_ctx_data <= i_ctx_data;
                        r_ctx_cnt  <= r_ctx_cnt + CTXN_W'(1);
                        if (r_ctx_cnt == r_ctx_num - CTXN_W'(1)) r_state <= S_INIT_ST;
                    end
                end
                S_INIT_ST: begin
                    if (r_row == w_rows_m1) begin
                        r_row   <= '0;
                        r_state <= S_START;
                    end else begin
                        r_row <= r_row + CNT_W'(1);
                    end
                end
                S_START: begin
                    r_cyc   <= 32'd1;
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    // r_cyc equals the number of cycles elapsed since the start pulse.
                    if (i_qea_complete) begin
                        r_state <= S_RD_REQ;
`ifdef QEA_SEQ_CYCLE_COUNT_EN
                        r_run_cycles <= r_cyc;
`endif
                    end else if (r_cyc >= 32'(TIMEOUT_CYCLES - 1)) begin
                        r_error <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_cyc <= r_cyc + 32'd1;
                    end
                end
                S_RD_REQ: r_state <= S_RD_WAIT;
                S_RD_WAIT: begin
                    r_rd_data  <= i_state_dout;
                    r_rd_last  <= (r_row == w_rows_m1);
                    r_rd_valid <= 1'b1;
                    r_state    <= S_RD_OUT;
                end
                S_RD_OUT: begin
                    if (i_rd_ready) begin
                        r_rd_valid <= 1'b0;
                        if (r_rd_last) begin
                            r_row   <= '0;
                            r_state <= S_IDLE;
                        end else begin
                            r_row   <= r_row + CNT_W'(1);
                            r_state <= S_RD_REQ;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qea_job_sequencer.sv
// Self-checking bench for qea_job_sequencer: randomized jobs against a queue-based reference model.
module tb_qea_job_sequencer;

    localparam int RW = 256;

    logic            clk = 1'b0;
    logic            rst;
    logic            i_job_valid;
    logic            o_job_ready;
    logic [5:0]      i_job_qbit_num;
    logic [16:0]     i_job_ctx_num;
    logic            i_ctx_valid;
    logic            o_ctx_ready;
    logic [63:0]     i_ctx_data;
    logic            o_qea_start;
    logic [5:0]      o_qea_qbit_num;
    logic            o_ctx_en;
    logic            o_ctx_wea;
    logic [15:0]     o_ctx_addr;
    logic [63:0]     o_ctx_data;
    logic            o_state_ena;
    logic            o_state_wea;
    logic [15:0]     o_state_addra;
    logic [RW-1:0]   o_state_dina;
    logic            i_qea_complete;
    logic [RW-1:0]   i_state_dout;
    logic            o_rd_valid;
    logic            i_rd_ready;
    logic [RW-1:0]   o_rd_data;
    logic            o_rd_last;
    logic            o_busy;
    logic            o_error;
`ifdef QEA_SEQ_CYCLE_COUNT_EN
    logic [31:0]     o_run_cycles;
`endif

    qea_job_sequencer #(.TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .rst(rst),
        .i_job_valid(i_job_valid), .o_job_ready(o_job_ready),
        .i_job_qbit_num(i_job_qbit_num), .i_job_ctx_num(i_job_ctx_num),
        .i_ctx_valid(i_ctx_valid), .o_ctx_ready(o_ctx_ready), .i_ctx_data(i_ctx_data),
        .o_qea_start(o_qea_start), .o_qea_qbit_num(o_qea_qbit_num),
        .o_ctx_en(o_ctx_en), .o_ctx_wea(o_ctx_wea), .o_ctx_addr(o_ctx_addr), .o_ctx_data(o_ctx_data),
        .o_state_ena(o_state_ena), .o_state_wea(o_state_wea), .o_state_addra(o_state_addra),
        .o_state_dina(o_state_dina), .i_qea_complete(i_qea_complete), .i_state_dout(i_state_dout),
        .o_rd_valid(o_rd_valid), .i_rd_ready(i_rd_ready), .o_rd_data(o_rd_data), .o_rd_last(o_rd_last),
        .o_busy(o_busy), .o_error(o_error)
`ifdef QEA_SEQ_CYCLE_COUNT_EN
        , .o_run_cycles(o_run_cycles)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // State RAM model with one-cycle registered read; contents are written by the bench acting as the QEA.
    logic [RW-1:0] ram [0:63];
    always @(posedge clk)
        if (o_state_ena && !o_state_wea) i_state_dout <= ram[o_state_addra[5:0]];

    int            ctx_addr_q[$];
    logic [63:0]   ctx_data_q[$];
    bit            ctx_wea_q[$];
    int            stw_addr_q[$];
    logic [RW-1:0] stw_data_q[$];
    logic [RW-1:0] rd_data_q[$];
    bit            rd_last_q[$];
    int            start_cnt = 0;
    int            err_cnt = 0;
    int            stall_bad = 0;
    logic          p_valid = 1'b0;
    logic          p_ready = 1'b0;
    logic          p_last = 1'b0;
    logic [RW-1:0] p_data = '0;

    always @(negedge clk) begin
        if (o_ctx_en) begin
            ctx_addr_q.push_back(int'(o_ctx_addr));
            ctx_data_q.push_back(o_ctx_data);
            ctx_wea_q.push_back(o_ctx_wea);
        end
        if (o_state_ena && o_state_wea) begin
            stw_addr_q.push_back(int'(o_state_addra));
            stw_data_q.push_back(o_state_dina);
        end
        if (o_rd_valid && i_rd_ready) begin
            rd_data_q.push_back(o_rd_data);
            rd_last_q.push_back(o_rd_last);
        end
        if (o_qea_start) start_cnt <= start_cnt + 1;
        if (o_error)     err_cnt <= err_cnt + 1;
        if (p_valid && !p_ready && !rst &&
            (!o_rd_valid || o_rd_data !== p_data || o_rd_last !== p_last))
            stall_bad <= stall_bad + 1;
        p_valid <= o_rd_valid;
        p_ready <= i_rd_ready;
        p_data  <= o_rd_data;
        p_last  <= o_rd_last;
    end

    logic [63:0] cur_beats[$];

    task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic submit(input int q, input int c, input string tag);
        bit rdy = 0;
        for (int k = 0; k < 100; k++) begin
            if (o_job_ready) begin rdy = 1; break; end
            step();
        end
        check({tag, "_job_ready"}, rdy, 1);
        i_job_valid = 1'b1;
        i_job_qbit_num = 6'(q);
        i_job_ctx_num = 17'(c);
        step();
        i_job_valid = 1'b0;
    endtask

    task automatic feed_ctx(input int n);
        bit rdy;
        cur_beats.delete();
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) begin i_ctx_valid = 1'b0; step(); end
            cur_beats.push_back({$urandom, $urandom});
            i_ctx_valid = 1'b1;
            i_ctx_data = cur_beats[i];
            for (int k = 0; k < 20; k++) begin
                rdy = o_ctx_ready;
                step();
                if (rdy) break;
            end
        end
        i_ctx_valid = 1'b0;
    endtask

    task automatic run_job(input int q, input int nctx, input int dly, input int rmode, input string tag);
        int rows, c0, s0, r0, st0, e0, sb0, n;
        bit got = 0;
        logic [RW-1:0] exp_rows[$];
        logic [RW-1:0] row0, w;
        rows = 1 << (q - 2);
        row0 = 256'h4000_0000_0000_0000 << 192;
        c0 = ctx_addr_q.size(); s0 = stw_addr_q.size(); r0 = rd_data_q.size();
        st0 = start_cnt; e0 = err_cnt; sb0 = stall_bad;
        submit(q, nctx, tag);
        feed_ctx(nctx);
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (o_qea_start) begin got = 1; break; end
        end
        check({tag, "_start_seen"}, got, 1);
        if (got) begin
            check({tag, "_busy_at_start"}, o_busy, 1);
            check({tag, "_qbit_out"}, o_qea_qbit_num, q);
            for (int r = 0; r < rows; r++) begin
                for (int k = 0; k < 8; k++) w[k*32 +: 32] = $urandom;
                ram[r] = w;
                exp_rows.push_back(w);
            end
            for (int d = 0; d < dly; d++) step();
            i_qea_complete = 1'b1;
            step();
            i_qea_complete = 1'b0;
            for (int k = 0; k < rows*12 + 50; k++) begin
                if (rmode == 0)      i_rd_ready = 1'b1;
                else if (rmode == 1) i_rd_ready = (k % 2 == 0);
                else                 i_rd_ready = 1'($urandom_range(0, 1));
                step();
                if (rd_data_q.size() - r0 >= rows && o_job_ready) break;
            end
            i_rd_ready = 1'b0;
        end
        step(); step();
        n = ctx_addr_q.size() - c0;
        check({tag, "_ctx_count"}, n, nctx);
        for (int i = 0; i < n && i < nctx; i++) begin
            check($sformatf("%s_ctx_addr%0d", tag, i), ctx_addr_q[c0+i], i);
            check($sformatf("%s_ctx_data%0d", tag, i), ctx_data_q[c0+i], cur_beats[i]);
            check($sformatf("%s_ctx_wea%0d", tag, i), ctx_wea_q[c0+i], 1);
        end
        n = stw_addr_q.size() - s0;
        check({tag, "_init_count"}, n, rows);
        for (int i = 0; i < n && i < rows; i++) begin
            check($sformatf("%s_init_addr%0d", tag, i), stw_addr_q[s0+i], i);
            check($sformatf("%s_init_data%0d", tag, i), stw_data_q[s0+i], (i == 0) ? row0 : '0);
        end
        n = rd_data_q.size() - r0;
        check({tag, "_beat_count"}, n, rows);
        for (int i = 0; i < n && i < rows; i++) begin
            check($sformatf("%s_beat_data%0d", tag, i), rd_data_q[r0+i], exp_rows[i]);
            check($sformatf("%s_beat_last%0d", tag, i), rd_last_q[r0+i], (i == rows-1));
        end
        check({tag, "_start_pulses"}, start_cnt - st0, 1);
        check({tag, "_no_error"}, err_cnt - e0, 0);
        check({tag, "_stall_stable"}, stall_bad - sb0, 0);
        check({tag, "_ready_after"}, o_job_ready, 1);
        $display("job %s qbit=%0d ctx=%0d rows=%0d beats=%0d", tag, q, nctx, rows, n);
    endtask

    task automatic err_job(input int q, input int c, input string tag);
        int s0, c0, st0;
        s0 = stw_addr_q.size(); c0 = ctx_addr_q.size(); st0 = start_cnt;
        i_job_valid = 1'b1;
        i_job_qbit_num = 6'(q);
        i_job_ctx_num = 17'(c);
        step();
        i_job_valid = 1'b0;
        @(negedge clk);
        check({tag, "_err_pulse"}, o_error, 1);
        check({tag, "_err_idle"}, o_busy, 0);
        @(negedge clk);
        check({tag, "_err_one_cycle"}, o_error, 0);
        @(posedge clk); #1;
        repeat (3) step();
        check({tag, "_no_state_writes"}, stw_addr_q.size() - s0, 0);
        check({tag, "_no_ctx_writes"}, ctx_addr_q.size() - c0, 0);
        check({tag, "_no_start"}, start_cnt - st0, 0);
        check({tag, "_ready"}, o_job_ready, 1);
        $display("job %s qbit=%0d ctx=%0d rejected", tag, q, c);
    endtask

    initial begin
        int t_start, t_err, s0, c0, r0, st0;
        bit found;
        rst = 1'b1; i_job_valid = 1'b0; i_job_qbit_num = '0; i_job_ctx_num = '0;
        i_ctx_valid = 1'b0; i_ctx_data = '0; i_qea_complete = 1'b0; i_rd_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", o_busy, 0);
        check("rst_error", o_error, 0);
        check("rst_start", o_qea_start, 0);
        check("rst_ctx_en", o_ctx_en, 0);
        check("rst_state_ena", o_state_ena, 0);
        check("rst_rd_valid", o_rd_valid, 0);
        check("rst_state_addr", o_state_addra, 0);
        check("rst_rd_data", o_rd_data, 0);
        rst = 1'b0;
        step();
        check("rst_job_ready", o_job_ready, 1);
        $display("reset checked");

        // A stray completion while idle must not start anything.
        i_qea_complete = 1'b1; step(); step(); i_qea_complete = 1'b0; step();
        check("stray_complete_idle", o_busy, 0);

        run_job(6, 3, 10, 0, "directed_q6");
        run_job(6, 4, 12, 1, "toggle_ready");
        run_job(2, 1, 1, 0, "single_row");
        for (int j = 0; j < 6; j++)
            run_job($urandom_range(2, 6), $urandom_range(1, 6), $urandom_range(1, 40),
                    $urandom_range(0, 2), $sformatf("rand%0d", j));

        err_job(1, 3, "qbit_low");
        err_job(4, 0, "ctx_zero");
        err_job(19, 2, "qbit_high");

        // Completion never arrives: timeout error 64 cycles after the start pulse.
        r0 = rd_data_q.size();
        submit(3, 1, "timeout");
        feed_ctx(1);
        found = 0; t_start = 0; t_err = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (o_qea_start) begin found = 1; t_start = cyc; break; end
        end
        check("timeout_start_seen", found, 1);
        found = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (o_error) begin found = 1; t_err = cyc; break; end
        end
        check("timeout_err_seen", found, 1);
        check("timeout_latency", t_err - t_start, 64);
        check("timeout_job_ready", o_job_ready, 1);
        @(negedge clk);
        check("timeout_err_one_cycle", o_error, 0);
        @(posedge clk); #1;
        check("timeout_no_beats", rd_data_q.size() - r0, 0);
        $display("job timeout latency=%0d", t_err - t_start);

        // Reset while the sixth init row is being written.
        s0 = stw_addr_q.size(); c0 = ctx_addr_q.size(); r0 = rd_data_q.size(); st0 = start_cnt;
        submit(6, 1, "midreset");
        feed_ctx(1);
        found = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (o_state_ena && o_state_wea && o_state_addra == 16'd5) begin found = 1; break; end
        end
        check("midreset_row5_seen", found, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midreset_rows_before", stw_addr_q.size() - s0, 6);
        step();
        rst = 1'b0;
        repeat (20) step();
        check("midreset_rows_after", stw_addr_q.size() - s0, 6);
        check("midreset_ctx_writes", ctx_addr_q.size() - c0, 1);
        check("midreset_no_beats", rd_data_q.size() - r0, 0);
        check("midreset_no_start", start_cnt - st0, 0);
        check("midreset_idle", o_busy, 0);
        check("midreset_ready", o_job_ready, 1);
        $display("job midreset rows_written=%0d", stw_addr_q.size() - s0);

        run_job($urandom_range(3, 6), $urandom_range(1, 4), $urandom_range(1, 30), 2, "after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
